// File: rtl/ext_mem_loader.sv
// rtl/ext_mem_loader.sv - byte-stream sequencer for IRAM/DRAM load, run window and DRAM readback
module ext_mem_loader #(
  parameter int SETUP_CYC = 2,
  parameter int WR_HOLD   = 4,
  parameter int RD_WAIT   = 5,
  parameter int ADDR_BASE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        start,
  output logic        start_2,
  output logic        start_3,
  output logic        start_4,
  output logic [8:0]  addr_ext,
  output logic        iram_write_ext_1,
  output logic        iram_write_ext_2,
  output logic        dram_write_ext,
  output logic        read_en_ext,
  output logic [15:0] Data_in_ins,
  output logic [15:0] Data_in_dram,
  input  logic [15:0] dram_in,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, HDR, GET_HI, GET_LO, WR_SETUP, WR_STROBE, WR_NEXT, RUN, RB_RD, RB_TX_HI, RB_TX_LO
  } state_t;

  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(WR_HOLD - 1);
  localparam logic [15:0] RD_LAST    = 16'(RD_WAIT - 1);
  localparam logic [15:0] CNT_MAX    = 16'(512 - ADDR_BASE);

  state_t      state, state_n;
  logic [2:0]  cmd, cmd_n;
  logic [1:0]  hdr_cnt, hdr_cnt_n, hdr_last;
  logic [23:0] hdr, hdr_n;
  logic [31:0] hdr_full;
  logic [9:0]  words_left, words_n;
  logic [15:0] cyc, cyc_n;
  logic [23:0] run_cnt, run_n;
  logic [8:0]  addr_n, rb_end, end_n;
  logic [7:0]  data_hi, hi_n;
  logic [15:0] rd_word, rdw_n, ins_n, dram_n;
  logic        err_n, alive, accept, load_mode, wr_phase;

  // alive keeps rx_ready low while reset is held even though state reads IDLE
  assign rx_ready  = alive && (state inside {IDLE, HDR, GET_HI, GET_LO});
  assign accept    = rx_valid && rx_ready;
  assign hdr_full  = {hdr, rx_data};
  assign hdr_last  = (cmd == 3'd4) ? 2'd2 : (cmd == 3'd5) ? 2'd3 : 2'd1;
  assign load_mode = state inside {GET_HI, GET_LO, WR_SETUP, WR_STROBE, WR_NEXT};
  assign wr_phase  = (state == WR_STROBE);

  assign busy             = (state != IDLE);
  assign start            = (state == RUN);
  assign start_2          = load_mode && (cmd != 3'd3);
  assign start_3          = load_mode && (cmd == 3'd3);
  assign start_4          = state inside {RB_RD, RB_TX_HI, RB_TX_LO};
  assign iram_write_ext_1 = wr_phase && (cmd == 3'd1);
  assign iram_write_ext_2 = wr_phase && (cmd == 3'd2);
  assign dram_write_ext   = wr_phase && (cmd == 3'd3);
  assign read_en_ext      = (state == RB_RD);
  assign tx_valid         = state inside {RB_TX_HI, RB_TX_LO};
  assign tx_data          = (state == RB_TX_HI) ? rd_word[15:8] :
                            (state == RB_TX_LO) ? rd_word[7:0] : 8'h00;

  always_comb begin
    state_n   = state;
    cmd_n     = cmd;
    hdr_cnt_n = hdr_cnt;
    hdr_n     = hdr;
    words_n   = words_left;
    cyc_n     = cyc;
    run_n     = run_cnt;
    addr_n    = addr_ext;
    end_n     = rb_end;
    hi_n      = data_hi;
    rdw_n     = rd_word;
    ins_n     = Data_in_ins;
    dram_n    = Data_in_dram;
    err_n     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (rx_data >= 8'h01 && rx_data <= 8'h05) begin
          cmd_n     = rx_data[2:0];
          hdr_cnt_n = 2'd0;
          state_n   = HDR;
        end else begin
          err_n = 1'b1;
        end
      end
      HDR: if (accept) begin
        hdr_n     = hdr_full[23:0];
        hdr_cnt_n = hdr_cnt + 2'd1;
        if (hdr_cnt == hdr_last) begin
          state_n = IDLE;
          if (cmd == 3'd4) begin
            run_n = hdr_full[23:0];
            if (hdr_full[23:0] != 24'd0) state_n = RUN;
          end else if (cmd == 3'd5) begin
            if (hdr_full[31:16] > 16'd511 || hdr_full[15:0] > 16'd511) begin
              err_n = 1'b1;
            end else if (hdr_full[31:16] < hdr_full[15:0]) begin
              addr_n  = hdr_full[24:16];
              end_n   = hdr_full[8:0];
              cyc_n   = 16'd0;
              state_n = RB_RD;
            end
          end else if (hdr_full[15:0] > CNT_MAX) begin
            err_n = 1'b1;
          end else if (hdr_full[15:0] != 16'd0) begin
            addr_n  = 9'(ADDR_BASE);
            words_n = hdr_full[9:0];
            state_n = GET_HI;
          end
        end
      end
      GET_HI: if (accept) begin
        hi_n    = rx_data;
        state_n = GET_LO;
      end
      GET_LO: if (accept) begin
        if (cmd == 3'd3) dram_n = {data_hi, rx_data};
        else             ins_n  = {data_hi, rx_data};
        cyc_n   = 16'd0;
        state_n = WR_SETUP;
      end
      WR_SETUP: if (cyc == SETUP_LAST) begin
        cyc_n   = 16'd0;
        state_n = WR_STROBE;
      end else cyc_n = cyc + 16'd1;
      WR_STROBE: if (cyc == HOLD_LAST) begin
        cyc_n   = 16'd0;
        state_n = WR_NEXT;
      end else cyc_n = cyc + 16'd1;
      // The final word leaves addr_ext on the last written address
      WR_NEXT: if (words_left == 10'd1) begin
        state_n = IDLE;
      end else begin
        words_n = words_left - 10'd1;
        addr_n  = addr_ext + 9'd1;
        state_n = GET_HI;
      end
      RUN: if (run_cnt == 24'd1) state_n = IDLE;
           else run_n = run_cnt - 24'd1;
      RB_RD: if (cyc == RD_LAST) begin
        rdw_n   = dram_in;
        state_n = RB_TX_HI;
      end else cyc_n = cyc + 16'd1;
      RB_TX_HI: if (tx_ready) state_n = RB_TX_LO;
      RB_TX_LO: if (tx_ready) begin
        addr_n  = addr_ext + 9'd1;
        cyc_n   = 16'd0;
        state_n = (addr_ext + 9'd1 == rb_end) ? IDLE : RB_RD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cmd          <= 3'd0;
      hdr_cnt      <= 2'd0;
      hdr          <= 24'd0;
      words_left   <= 10'd0;
      cyc          <= 16'd0;
      run_cnt      <= 24'd0;
      addr_ext     <= 9'd0;
      rb_end       <= 9'd0;
      data_hi      <= 8'd0;
      rd_word      <= 16'd0;
      Data_in_ins  <= 16'd0;
      Data_in_dram <= 16'd0;
      err          <= 1'b0;
      alive        <= 1'b0;
    end else begin
      state        <= state_n;
      cmd          <= cmd_n;
      hdr_cnt      <= hdr_cnt_n;
      hdr          <= hdr_n;
      words_left   <= words_n;
      cyc          <= cyc_n;
      run_cnt      <= run_n;
      addr_ext     <= addr_n;
      rb_end       <= end_n;
      data_hi      <= hi_n;
      rd_word      <= rdw_n;
      Data_in_ins  <= ins_n;
      Data_in_dram <= dram_n;
      err          <= err_n;
      alive        <= 1'b1;
    end
  end

endmodule
